// File: rtl/kyber_pkg.sv
// Shared Kyber constants plus coefficient/byte indexing and freeze helpers,
// used by both the pack and unpack datapaths.
package kyber_pkg;

  localparam int KYBER_Q         = 3329;
  localparam int KYBER_N         = 256;
  localparam int COEFF_W         = 16;
  localparam int PACKED_W        = 12;
  localparam int COEFFS_PER_BEAT = 8;
  localparam int BYTES_PER_BEAT  = 12;

  function automatic int coeff_msb(input int n);
    return COEFFS_PER_BEAT * COEFF_W - 1 - COEFF_W * n;
  endfunction

  function automatic int byte_msb(input int k);
    return BYTES_PER_BEAT * 8 - 1 - 8 * k;
  endfunction

  // Conditional add of q, keeping only the low 12 bits.
  function automatic logic [PACKED_W-1:0] freeze12(input logic [COEFF_W-1:0] c,
                                                   input logic [COEFF_W-1:0] q);
    logic [COEFF_W-1:0] s;
    s = c + (c[COEFF_W-1] ? q : 16'd0);
    return s[PACKED_W-1:0];
  endfunction

  function automatic logic out_of_range(input logic [COEFF_W-1:0] c,
                                        input logic [COEFF_W-1:0] q);
    return ($signed(c) < -$signed(q)) || ($signed(c) > $signed(q - 16'd1));
  endfunction

endpackage

// File: rtl/poly_tobytes_pack8.sv
// Combinational freeze-and-pack of 8 signed coefficients into 12 bytes,
// with a flag for any coefficient outside [-q, q-1].
module poly_tobytes_pack8
  import kyber_pkg::*;
#(
  parameter int KYBER_Q = 3329
) (
  input  logic [127:0] coeffs_i,
  output logic [95:0]  bytes_o,
  output logic         range_err_o
);

  localparam logic [15:0] Q16 = 16'(KYBER_Q);

  always_comb begin
    logic [11:0] t0;
    logic [11:0] t1;
    bytes_o     = 96'd0;
    range_err_o = 1'b0;
    t0          = 12'd0;
    t1          = 12'd0;
    for (int p = 0; p < 4; p++) begin
      t0 = freeze12(coeffs_i[coeff_msb(2*p) -: 16], Q16);
      t1 = freeze12(coeffs_i[coeff_msb(2*p+1) -: 16], Q16);
      bytes_o[byte_msb(3*p)   -: 8] = t0[7:0];
      bytes_o[byte_msb(3*p+1) -: 8] = {t1[3:0], t0[11:8]};
      bytes_o[byte_msb(3*p+2) -: 8] = t1[11:4];
    end
    for (int n = 0; n < 8; n++) begin
      if (out_of_range(coeffs_i[coeff_msb(n) -: 16], Q16)) begin
        range_err_o = 1'b1;
      end else begin
        range_err_o = range_err_o;
      end
    end
  end

endmodule

// File: rtl/state_pack_poly_tobytes_stream.sv
// Streaming polynomial-to-bytes serializer: one registered valid/ready stage
// carrying 12 packed bytes per beat, framed into 32-beat polynomials.
module state_pack_poly_tobytes_stream
  import kyber_pkg::*;
#(
  parameter int BEATS_PER_POLY = 32,
  parameter int KYBER_Q        = 3329
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_coeffs,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [95:0]  m_bytes,
  output logic         m_last,
  output logic         range_err
);

  localparam int CNT_W = (BEATS_PER_POLY > 1) ? $clog2(BEATS_PER_POLY) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_POLY - 1);

  logic [95:0]      packed_s;
  logic             beat_err_s;
  logic             accept_s;
  logic             m_valid_q, m_valid_d;
  logic [95:0]      m_bytes_q, m_bytes_d;
  logic             m_last_q, m_last_d;
  logic             range_err_q, range_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  poly_tobytes_pack8 #(.KYBER_Q(KYBER_Q)) u_pack (
    .coeffs_i    (s_coeffs),
    .bytes_o     (packed_s),
    .range_err_o (beat_err_s)
  );

  // clr blocks acceptance so a beat presented alongside it is dropped.
  assign s_ready  = !clr && (!m_valid_q || m_ready);
  assign accept_s = s_valid && s_ready;

  always_comb begin
    m_valid_d   = m_valid_q;
    m_bytes_d   = m_bytes_q;
    m_last_d    = m_last_q;
    range_err_d = range_err_q;
    cnt_d       = cnt_q;
    if (clr) begin
      m_valid_d   = 1'b0;
      cnt_d       = '0;
      range_err_d = 1'b0;
    end else if (accept_s) begin
      m_valid_d   = 1'b1;
      m_bytes_d   = packed_s;
      m_last_d    = (cnt_q == LAST_BEAT);
      cnt_d       = (cnt_q == LAST_BEAT) ? '0 : cnt_q + 1'b1;
      range_err_d = range_err_q | beat_err_s;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q   <= 1'b0;
      m_bytes_q   <= 96'd0;
      m_last_q    <= 1'b0;
      range_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_bytes_q   <= m_bytes_d;
      m_last_q    <= m_last_d;
      range_err_q <= range_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_bytes   = m_bytes_q;
  assign m_last    = m_last_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_state_pack_poly_tobytes_stream.sv
// Scoreboard bench: the driver pushes expected beats on acceptance, a negedge
// monitor compares every presented output beat against the queue head.
module tb_state_pack_poly_tobytes_stream;

  localparam int BEATS = 32;

  logic         clk = 1'b0;
  logic         rst, clr, s_valid, s_ready, m_valid, m_ready, m_last, range_err;
  logic [127:0] s_coeffs;
  logic [95:0]  m_bytes;

  typedef struct {
    logic [95:0] bytes;
    logic        last;
    logic        rt;
    logic [95:0] ts;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   idx      = 0;

  state_pack_poly_tobytes_stream #(.BEATS_PER_POLY(BEATS), .KYBER_Q(3329)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_coeffs(s_coeffs),
    .m_valid(m_valid), .m_ready(m_ready), .m_bytes(m_bytes),
    .m_last(m_last), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 96'(act), 96'(exp));
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Canonical values as a little-endian 12-bit stream (coeff i at bits 12i).
  function automatic logic [95:0] model_ts(input logic [127:0] c);
    logic [95:0] ts;
    ts = 96'd0;
    for (int i = 0; i < 8; i++) begin
      int v;
      v = $signed(c[127-16*i -: 16]);
      v = v % 3329;
      if (v < 0) v = v + 3329;
      ts[12*i +: 12] = 12'(v);
    end
    return ts;
  endfunction

  function automatic logic [95:0] le_to_bytes(input logic [95:0] ts);
    logic [95:0] b;
    for (int k = 0; k < 12; k++) b[95-8*k -: 8] = ts[8*k +: 8];
    return b;
  endfunction

  function automatic logic [95:0] bytes_to_le(input logic [95:0] b);
    logic [95:0] ts;
    for (int k = 0; k < 12; k++) ts[8*k +: 8] = b[95-8*k -: 8];
    return ts;
  endfunction

  function automatic logic [127:0] stream_c(input int b);
    logic [127:0] c;
    for (int i = 0; i < 8; i++) begin
      int v;
      v = ((b * 8 + i) * 397) % 6658 - 3329;
      c[127-16*i -: 16] = 16'(v);
    end
    return c;
  endfunction

  task automatic send(input logic [127:0] c, input logic [95:0] exp_bytes,
                      input logic rt, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    s_coeffs = c;
    s_valid  = 1'b1;
    while (!done && waits < 200) begin
      @(negedge clk);
      if (s_ready) begin
        sb.push_back('{exp_bytes, (idx == BEATS - 1), rt, model_ts(c)});
        idx  = (idx == BEATS - 1) ? 0 : idx + 1;
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    if (!done) fail("send_timeout");
  endtask

  task automatic send_model(input logic [127:0] c, output int waits);
    send(c, le_to_bytes(model_ts(c)), 1'b1, waits);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (sb.size() != 0) fail("drain_timeout");
  endtask

  // Monitor: compare presented beat with queue head; pop on transfer.
  always @(negedge clk) begin
    if (!rst && m_valid) begin
      if (sb.size() == 0) begin
        fail("unexpected_beat");
      end else begin
        chk("m_bytes", m_bytes, sb[0].bytes);
        chk1("m_last", m_last, sb[0].last);
        if (m_ready) begin
          if (sb[0].rt) chk("roundtrip", bytes_to_le(m_bytes), sb[0].ts);
          sb.delete(0);
        end
      end
    end
  end

  localparam logic [127:0] V1    = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
  localparam logic [95:0]  E1    = 96'h012000_034000_056000_078000;
  localparam logic [127:0] VNEG  = {8{16'hFFFF}};
  localparam logic [95:0]  ENEG  = {4{24'h000DD0}};
  localparam logic [127:0] VMIX  = 128'hF2FF_0D00_0ABC_0123_0000_0000_0000_0000;
  localparam logic [95:0]  EMIX  = 96'h0000D0_BC3A12_000000_000000;
  localparam logic [127:0] VBAD  = 128'h0D01_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [95:0]  EBAD  = 96'h010D00_000000_000000_000000;

  initial begin
    int w;
    int stalls;
    rst = 1'b1; clr = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_coeffs = 128'd0;
    #2;
    chk1("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_bytes", m_bytes, 96'd0);
    chk1("rst_m_last", m_last, 1'b0);
    chk1("rst_range_err", range_err, 1'b0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    chk1("rst_s_ready", s_ready, 1'b1);
    m_ready = 1'b1;

    // 64 back-to-back beats: no stalls, m_last on beats 31 and 63.
    stalls = 0;
    for (int b = 0; b < 64; b++) begin
      send_model(stream_c(b), w);
      stalls += w;
    end
    chk("stream_stalls", 96'(stalls), 96'd0);
    drain();

    send(V1, E1, 1'b1, w);
    send(VNEG, ENEG, 1'b1, w);
    send(VMIX, EMIX, 1'b1, w);
    drain();
    chk1("range_err_clean", range_err, 1'b0);

    // Backpressure: downstream stalls for about five cycles.
    fork
      begin
        send(V1, E1, 1'b1, w);
        send(VNEG, ENEG, 1'b1, w);
        send(VMIX, EMIX, 1'b1, w);
      end
      begin
        m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1("bp_s_ready", s_ready, 1'b0);
        chk1("bp_m_valid", m_valid, 1'b1);
        repeat (4) @(posedge clk);
        #1 m_ready = 1'b1;
      end
    join
    drain();

    // Out-of-range coefficient sets a sticky flag; clr clears it.
    send(VBAD, EBAD, 1'b0, w);
    chk1("range_err_set", range_err, 1'b1);
    send(V1, E1, 1'b1, w);
    chk1("range_err_sticky", range_err, 1'b1);
    drain();
    m_ready = 1'b0;
    send(VMIX, EMIX, 1'b1, w);
    clr = 1'b1; s_valid = 1'b1; s_coeffs = V1;
    @(negedge clk);
    chk1("clr_s_ready", s_ready, 1'b0);
    @(posedge clk); #1;
    clr = 1'b0; s_valid = 1'b0;
    sb.delete();
    idx = 0;
    chk1("clr_m_valid", m_valid, 1'b0);
    chk1("clr_range_err", range_err, 1'b0);
    m_ready = 1'b1;
    send(VMIX, EMIX, 1'b1, w);
    drain();

    // Async reset after beat 10, then a full 32-beat polynomial.
    for (int b = 0; b < 11; b++) send_model(stream_c(b + 100), w);
    rst = 1'b1;
    #1;
    chk1("arst_m_valid", m_valid, 1'b0);
    chk("arst_m_bytes", m_bytes, 96'd0);
    chk1("arst_m_last", m_last, 1'b0);
    chk1("arst_range_err", range_err, 1'b0);
    sb.delete();
    idx = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int b = 0; b < 32; b++) send_model(stream_c(b + 200), w);
    drain();
    chk("sb_empty", 96'(sb.size()), 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
